// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared definitions for the flush_fifo family and its checkers.
//   clog2()            : ceiling log2 used to size pointers and the occupancy count
//   AF_MARGIN_DEFAULT  : default distance of the almost-full threshold below DEPTH
//   AE_LEVEL_DEFAULT   : default almost-empty threshold
//   fifo_op_e          : per-cycle operation taken on the update edge
package fifo_pkg;

  // Smallest n with 2**n >= value (never less than 1, so a vector is always legal).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  localparam int AF_MARGIN_DEFAULT = 2;
  localparam int AE_LEVEL_DEFAULT  = 1;

  typedef enum logic [2:0] {
    OP_IDLE   = 3'd0,  // nothing happens (or request dropped)
    OP_FLUSH  = 3'd1,  // discard everything, pointers to 0
    OP_BYPASS = 3'd2,  // empty queue, word passes straight through
    OP_RDWR   = 3'd3,  // pop and push together, count unchanged
    OP_RD     = 3'd4,  // pop only
    OP_WR     = 3'd5   // push only
  } fifo_op_e;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr -- modulo-DEPTH pointer register, updated on the falling clock edge.
//   CLK   : clock, state changes on negedge
//   RST   : asynchronous active-high reset, pointer -> 0
//   clear : synchronous return to 0 (wins over inc)
//   inc   : advance by one, wrapping DEPTH-1 -> 0
//   ptr   : current pointer value
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Explicit wrap so non-power-of-two depths never visit unused slots.
  always_comb begin
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PW'(1);
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/flush_fifo.sv
// flush_fifo -- single-clock FIFO for Tomasulo-side queues, any DEPTH >= 2,
// with empty fall-through bypass, synchronous flush and occupancy thresholds.
// All state changes on the falling edge of CLK; RST is asynchronous.
//   CLK, RST     : clock (negedge-updated) and async active-high reset
//   flush        : discard all contents this cycle
//   read_flag    : consumer pops the head
//   read_data    : head entry, or write_data while bypassing
//   write_flag   : producer pushes write_data
//   write_data   : push data
//   empty / full : no word available / no slot available this cycle
//   count        : registered occupancy 0..DEPTH
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   overflow / underflow : sticky dropped-request flags, present only when
//                  FIFO_ERR_CHK_EN is defined
module flush_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - AF_MARGIN_DEFAULT,
  parameter int AE_LEVEL = AE_LEVEL_DEFAULT
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        flush,
  input  logic                        read_flag,
  output logic [WIDTH-1:0]            read_data,
  input  logic                        write_flag,
  input  logic [WIDTH-1:0]            write_data,
  output logic                        empty,
  output logic                        full,
  output logic [clog2(DEPTH+1)-1:0]   count,
  output logic                        almost_full,
`ifdef FIFO_ERR_CHK_EN
  output logic                        overflow,
  output logic                        underflow,
`endif
  output logic                        almost_empty
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = clog2(DEPTH);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [PW-1:0]    read_ptr;
  logic [PW-1:0]    write_ptr;

  logic     cnt_zero;
  logic     rd;
  logic     wr;
  logic     rd_inc;
  logic     wr_inc;
  logic     ptr_clear;
  fifo_op_e op;

  assign cnt_zero = (count_q == '0);

  // A push into an empty queue is immediately readable, so it is not "empty".
  assign empty = flush | (cnt_zero & ~write_flag);
  // A pop from a full queue frees the head slot in the same cycle.
  assign full  = flush | ((count_q == FULL_C) & ~read_flag);
  assign rd    = read_flag & ~empty;
  assign wr    = write_flag & ~full;

  always_comb begin
    op = OP_IDLE;
    if (flush) begin
      op = OP_FLUSH;
    end else if (rd && wr && cnt_zero) begin
      op = OP_BYPASS;
    end else if (rd && wr) begin
      op = OP_RDWR;
    end else if (rd) begin
      op = OP_RD;
    end else if (wr) begin
      op = OP_WR;
    end
  end

  assign ptr_clear = (op == OP_FLUSH);
  assign rd_inc    = (op == OP_RDWR) || (op == OP_RD);
  assign wr_inc    = (op == OP_RDWR) || (op == OP_WR);

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_read_ptr (
    .CLK   (CLK),
    .RST   (RST),
    .clear (ptr_clear),
    .inc   (rd_inc),
    .ptr   (read_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .PW(PW)) u_write_ptr (
    .CLK   (CLK),
    .RST   (RST),
    .clear (ptr_clear),
    .inc   (wr_inc),
    .ptr   (write_ptr)
  );

  always_comb begin
    count_d = count_q;
    case (op)
      OP_FLUSH: count_d = '0;
      OP_RD:    count_d = count_q - CW'(1);
      OP_WR:    count_d = count_q + CW'(1);
      default:  count_d = count_q;
    endcase
  end

  // Flush leaves the storage untouched; only the pointers forget it.
  always_comb begin
    mem_d = mem_q;
    if (wr_inc) begin
      mem_d[write_ptr] = write_data;
    end
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  assign read_data    = (cnt_zero && write_flag) ? write_data : mem_q[read_ptr];
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

`ifdef FIFO_ERR_CHK_EN
  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  // A flushing cycle forces empty/full high but is not a producer/consumer error.
  always_comb begin
    overflow_d  = overflow_q  | (write_flag & full  & ~flush);
    underflow_d = underflow_q | (read_flag  & empty & ~flush);
  end

  always_ff @(negedge CLK or posedge RST) begin
    if (RST) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_flush_fifo.sv
module tb_flush_fifo;

  logic       CLK;
  logic       RST;
  logic       flush;
  logic       read_flag;
  logic [7:0] read_data;
  logic       write_flag;
  logic [7:0] write_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       almost_full;
  logic       almost_empty;
`ifdef FIFO_ERR_CHK_EN
  logic       overflow;
  logic       underflow;
`endif

  int total;
  int passed;

  flush_fifo #(.WIDTH(8), .DEPTH(6)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .flush        (flush),
    .read_flag    (read_flag),
    .read_data    (read_data),
    .write_flag   (write_flag),
    .write_data   (write_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .almost_full  (almost_full),
`ifdef FIFO_ERR_CHK_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .almost_empty (almost_empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       fl;
    logic       rd;
    logic       wr;
    logic [7:0] wd;
    logic       chk;
    logic [7:0] rdata;
    logic       empty;
    logic       full;
    int         count;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic fl, input logic rd, input logic wr, input int wd,
                     input logic chk, input int rdata, input logic e, input logic f,
                     input int cnt);
    vec_t v;
    v.fl = fl; v.rd = rd; v.wr = wr; v.wd = 8'(wd);
    v.chk = chk; v.rdata = 8'(rdata); v.empty = e; v.full = f; v.count = cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic rd, input logic wr, input int wd);
    flush = fl; read_flag = rd; write_flag = wr; write_data = 8'(wd);
  endtask

  initial begin
    total = 0;
    passed = 0;
    RST = 1'b1;
    drive(0, 0, 0, 0);

    // Fill/drain: six pushes, a dropped seventh, six pops, a dropped pop.
    add(0, 0, 0, 0, 1, 8'h00, 1, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 1, 8'h10 + i, 1, 8'h10, 0, 0, i);
    add(0, 0, 1, 8'h16, 1, 8'h10, 0, 1, 6);
    add(0, 0, 0, 0, 1, 8'h10, 0, 1, 6);
    for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 1, 8'h10 + i, 0, 0, 6 - i);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Wrap: push 4, pop 4, push 6 (write pointer wraps 5 -> 0), pop 6.
    for (int i = 0; i < 4; i++) add(0, 0, 1, 8'h20 + i, 1, 8'h20, 0, 0, i);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 1, 8'h20 + i, 0, 0, 4 - i);
    for (int i = 0; i < 6; i++) add(0, 0, 1, 8'h30 + i, 1, 8'h30, 0, 0, i);
    add(0, 0, 0, 0, 1, 8'h30, 0, 1, 6);
    for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 1, 8'h30 + i, 0, 0, 6 - i);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Bypass through an empty queue.
    add(0, 1, 1, 8'hA5, 1, 8'hA5, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Full with simultaneous push/pop.
    for (int i = 0; i < 6; i++) add(0, 0, 1, 8'h40 + i, 1, 8'h40, 0, 0, i);
    add(0, 1, 1, 8'h77, 1, 8'h40, 0, 0, 6);
    add(0, 0, 0, 0, 1, 8'h41, 0, 1, 6);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 1, 8'h41 + i, 0, 0, 6 - i);
    add(0, 1, 0, 0, 1, 8'h77, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // Flush at count 4 with push and pop requested.
    for (int i = 0; i < 4; i++) add(0, 0, 1, 8'h50 + i, 1, 8'h50, 0, 0, i);
    add(1, 1, 1, 8'h99, 1, 8'h50, 1, 1, 4);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 8'h3C, 1, 8'h3C, 0, 0, 0);
    add(0, 1, 0, 0, 1, 8'h3C, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);

    repeat (2) @(negedge CLK);
    #3 RST = 1'b0;
    @(negedge CLK);
    #1;
`ifdef FIFO_ERR_CHK_EN
    check("overflow_rst", 0, 32'(overflow), 32'd0);
    check("underflow_rst", 0, 32'(underflow), 32'd0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fl, vecs[i].rd, vecs[i].wr, int'(vecs[i].wd));
      @(posedge CLK);
      #1;
      $display("vec %0d fl=%0b rd=%0b wr=%0b wd=%02h -> rdata=%02h empty=%0b full=%0b count=%0d af=%0b ae=%0b",
               i, flush, read_flag, write_flag, write_data, read_data, empty, full, count,
               almost_full, almost_empty);
      check("count", i, 32'(count), 32'(vecs[i].count));
      check("empty", i, 32'(empty), 32'(vecs[i].empty));
      check("full", i, 32'(full), 32'(vecs[i].full));
      check("almost_full", i, 32'(almost_full), 32'(vecs[i].count >= 4));
      check("almost_empty", i, 32'(almost_empty), 32'(vecs[i].count <= 1));
      if (vecs[i].chk) check("read_data", i, 32'(read_data), 32'(vecs[i].rdata));
      @(negedge CLK);
      #1;
    end

`ifdef FIFO_ERR_CHK_EN
    check("overflow_sticky", 0, 32'(overflow), 32'd1);
    check("underflow_sticky", 0, 32'(underflow), 32'd1);
`endif

    // Async reset mid-burst: fill, overflow, then pulse RST between edges.
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 1, 8'h60 + i);
      @(negedge CLK);
      #1;
    end
    drive(0, 0, 0, 0);
    $display("burst full: count=%0d full=%0b", count, full);
    check("burst_count", 0, 32'(count), 32'd6);
`ifdef FIFO_ERR_CHK_EN
    check("burst_overflow", 0, 32'(overflow), 32'd1);
`endif
    #1 RST = 1'b1;
    #1;
    $display("async reset: count=%0d rdata=%02h empty=%0b", count, read_data, empty);
    check("arst_count", 0, 32'(count), 32'd0);
    check("arst_read_data", 0, 32'(read_data), 32'd0);
    check("arst_empty", 0, 32'(empty), 32'd1);
    check("arst_full", 0, 32'(full), 32'd0);
    check("arst_almost_empty", 0, 32'(almost_empty), 32'd1);
`ifdef FIFO_ERR_CHK_EN
    check("arst_overflow", 0, 32'(overflow), 32'd0);
    check("arst_underflow", 0, 32'(underflow), 32'd0);
`endif
    #1 RST = 1'b0;
    @(negedge CLK);
    #1;
    drive(0, 0, 1, 8'h81);
    @(posedge CLK);
    #1;
    $display("post reset push: rdata=%02h count=%0d", read_data, count);
    check("post_rst_bypass", 0, 32'(read_data), 32'h81);
    @(negedge CLK);
    #1;
    drive(0, 0, 0, 0);
    check("post_rst_count", 0, 32'(count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
